// File: rtl/frame_sequencer.sv
// Frame sequencer for a side-scrolling jump game: runs the per-frame update/check/kick
// phases, owns the rex jump arc, the obstacle scroll, scoring and game state.
module frame_sequencer #(
    parameter int unsigned SCREEN_W   = 128,
    parameter int unsigned REX_X      = 8,
    parameter int unsigned REX_W      = 16,
    parameter int unsigned OBST_W     = 8,
    parameter int unsigned OBST_H     = 15,
    parameter int unsigned INIT_SPEED = 2,
    parameter int unsigned MAX_SPEED  = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        frame_i,
    input  logic        jmp_key,
    output logic        start_o,
    output logic [15:0] rex_down,
    output logic [15:0] obstacle_left,
    output logic [1:0]  game_state,
    output logic [15:0] score_o
);

    localparam int unsigned DW  = 16;
    localparam int unsigned CW  = DW + 1;
    localparam int unsigned IW  = 4;
    localparam logic [DW-1:0] OBST_START = DW'(SCREEN_W - 1);
    localparam logic [DW-1:0] SPD_INIT   = DW'(INIT_SPEED);
    localparam logic [DW-1:0] SPD_MAX    = DW'(MAX_SPEED);
    localparam logic [DW-1:0] SCORE_MAX  = {DW{1'b1}};
    localparam logic [IW-1:0] JMP_LAST   = IW'(8);

    typedef enum logic [1:0] {PH_WAIT, PH_UPDATE, PH_CHECK, PH_KICK} phase_t;
    typedef enum logic [1:0] {GS_IDLE = 2'b00, GS_RUN = 2'b01, GS_OVER = 2'b10} gstate_t;

    // Jump arc, one entry per frame; the last entry lands the rex.
    function automatic logic [DW-1:0] jump_height(input logic [IW-1:0] idx);
        logic [DW-1:0] h;
        case (idx)
            4'd0:    h = DW'(15);
            4'd1:    h = DW'(27);
            4'd2:    h = DW'(34);
            4'd3:    h = DW'(36);
            4'd4:    h = DW'(36);
            4'd5:    h = DW'(34);
            4'd6:    h = DW'(27);
            4'd7:    h = DW'(15);
            default: h = '0;
        endcase
        return h;
    endfunction

    logic [1:0]    r_frame_sync;
    logic          r_frame_d;
    logic [1:0]    r_jmp_sync;
    logic          r_jmp_d;
    phase_t        r_phase;
    gstate_t       r_gs;
    logic          r_start;
    logic          r_jmp_req;
    logic          r_airborne;
    logic [IW-1:0] r_jmp_idx;
    logic [DW-1:0] r_rex;
    logic [DW-1:0] r_obst;
    logic [DW-1:0] r_score;
    logic [DW-1:0] r_speed;

    phase_t        w_phase_nxt;
    gstate_t       w_gs_nxt;
    logic          w_start_nxt;
    logic          w_jmp_req_nxt;
    logic          w_airborne_nxt;
    logic [IW-1:0] w_jmp_idx_nxt;
    logic [DW-1:0] w_rex_nxt;
    logic [DW-1:0] w_obst_nxt;
    logic [DW-1:0] w_score_nxt;
    logic [DW-1:0] w_speed_nxt;

    logic          w_frame_edge;
    logic          w_jmp_edge;
    logic          w_req;
    logic [CW-1:0] w_obst_ext;
    logic          w_collision;
    logic [DW-1:0] w_score_inc;

    assign w_frame_edge = r_frame_sync[1] & ~r_frame_d;
    assign w_jmp_edge   = r_jmp_sync[1] & ~r_jmp_d;
    assign w_req        = r_jmp_req | w_jmp_edge;
    assign w_score_inc  = r_score + DW'(1);

    assign w_obst_ext  = {1'b0, r_obst};
    assign w_collision = (w_obst_ext + CW'(OBST_W) > CW'(REX_X))
                      && (w_obst_ext < CW'(REX_X + REX_W))
                      && (r_rex < DW'(OBST_H));

    // Synchronizers and edge-detect history
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_sync <= '0;
            r_frame_d    <= 1'b0;
            r_jmp_sync   <= '0;
            r_jmp_d      <= 1'b0;
        end else begin
            r_frame_sync <= {r_frame_sync[0], frame_i};
            r_frame_d    <= r_frame_sync[1];
            r_jmp_sync   <= {r_jmp_sync[0], jmp_key};
            r_jmp_d      <= r_jmp_sync[1];
        end
    end

    // Phase and game state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase    <= PH_WAIT;
            r_gs       <= GS_IDLE;
            r_start    <= 1'b0;
            r_jmp_req  <= 1'b0;
            r_airborne <= 1'b0;
            r_jmp_idx  <= '0;
            r_rex      <= '0;
            r_obst     <= OBST_START;
            r_score    <= '0;
            r_speed    <= SPD_INIT;
        end else begin
            r_phase    <= w_phase_nxt;
            r_gs       <= w_gs_nxt;
            r_start    <= w_start_nxt;
            r_jmp_req  <= w_jmp_req_nxt;
            r_airborne <= w_airborne_nxt;
            r_jmp_idx  <= w_jmp_idx_nxt;
            r_rex      <= w_rex_nxt;
            r_obst     <= w_obst_nxt;
            r_score    <= w_score_nxt;
            r_speed    <= w_speed_nxt;
        end
    end

    // Next-state: phase sequencing plus per-frame game update
    always_comb begin
        w_phase_nxt    = r_phase;
        w_gs_nxt       = r_gs;
        w_start_nxt    = 1'b0;
        w_jmp_req_nxt  = w_req;
        w_airborne_nxt = r_airborne;
        w_jmp_idx_nxt  = r_jmp_idx;
        w_rex_nxt      = r_rex;
        w_obst_nxt     = r_obst;
        w_score_nxt    = r_score;
        w_speed_nxt    = r_speed;

        unique case (r_phase)
            PH_WAIT: begin
                if (w_frame_edge) w_phase_nxt = PH_UPDATE;
            end
            PH_UPDATE: begin
                w_phase_nxt   = PH_CHECK;
                w_jmp_req_nxt = 1'b0;
                case (r_gs)
                    GS_IDLE: begin
                        if (w_req) begin
                            w_gs_nxt       = GS_RUN;
                            w_score_nxt    = '0;
                            w_speed_nxt    = SPD_INIT;
                            w_obst_nxt     = OBST_START;
                            w_rex_nxt      = '0;
                            w_jmp_idx_nxt  = '0;
                            w_airborne_nxt = 1'b0;
                        end
                    end
                    GS_OVER: begin
                        if (w_req) begin
                            w_gs_nxt       = GS_IDLE;
                            w_obst_nxt     = OBST_START;
                            w_rex_nxt      = '0;
                            w_jmp_idx_nxt  = '0;
                            w_airborne_nxt = 1'b0;
                        end
                    end
                    GS_RUN: begin
                        // A request while airborne is simply dropped
                        if (r_airborne) begin
                            w_rex_nxt = jump_height(r_jmp_idx);
                            if (r_jmp_idx == JMP_LAST) begin
                                w_airborne_nxt = 1'b0;
                                w_jmp_idx_nxt  = '0;
                            end else begin
                                w_jmp_idx_nxt = r_jmp_idx + IW'(1);
                            end
                        end else if (w_req) begin
                            w_rex_nxt      = jump_height('0);
                            w_airborne_nxt = 1'b1;
                            w_jmp_idx_nxt  = IW'(1);
                        end

                        if (r_obst < r_speed) begin
                            w_obst_nxt = OBST_START;
                            if (r_score != SCORE_MAX) begin
                                w_score_nxt = w_score_inc;
                                if ((w_score_inc[2:0] == 3'd0) && (r_speed < SPD_MAX))
                                    w_speed_nxt = r_speed + DW'(1);
                            end
                        end else begin
                            w_obst_nxt = r_obst - r_speed;
                        end
                    end
                    default: ;
                endcase
            end
            PH_CHECK: begin
                w_phase_nxt = PH_KICK;
                w_start_nxt = 1'b1;
                if ((r_gs == GS_RUN) && w_collision) w_gs_nxt = GS_OVER;
            end
            PH_KICK: begin
                w_phase_nxt = PH_WAIT;
            end
            default: begin
                w_phase_nxt = PH_WAIT;
            end
        endcase
    end

    assign start_o       = r_start;
    assign rex_down      = r_rex;
    assign obstacle_left = r_obst;
    assign game_state    = r_gs;
    assign score_o       = r_score;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized bench for frame_sequencer: a per-frame game model predicts each start_o
// snapshot; a negedge monitor pops and compares whenever start_o fires.
module tb_frame_sequencer;

    localparam int SCREEN_W   = 128;
    localparam int REX_X      = 8;
    localparam int REX_W      = 4;
    localparam int OBST_W     = 4;
    localparam int OBST_H     = 15;
    localparam int INIT_SPEED = 2;
    localparam int MAX_SPEED  = 4;
    localparam int N_FRAMES   = 1400;
    localparam int CYC_LIMIT  = 90000;

    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_OVER = 2;

    typedef struct {
        int cyc;
        int gs;
        int rex;
        int ol;
        int score;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        frame_i;
    logic        jmp_key;
    logic        start_o;
    logic [15:0] rex_down;
    logic [15:0] obstacle_left;
    logic [1:0]  game_state;
    logic [15:0] score_o;

    frame_sequencer #(
        .SCREEN_W  (SCREEN_W),
        .REX_X     (REX_X),
        .REX_W     (REX_W),
        .OBST_W    (OBST_W),
        .OBST_H    (OBST_H),
        .INIT_SPEED(INIT_SPEED),
        .MAX_SPEED (MAX_SPEED)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .frame_i      (frame_i),
        .jmp_key      (jmp_key),
        .start_o      (start_o),
        .rex_down     (rex_down),
        .obstacle_left(obstacle_left),
        .game_state   (game_state),
        .score_o      (score_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 0;
    bit   ended = 0;

    // Game model state
    int   m_gs, m_score, m_spd, m_ol, m_rex;
    int   m_jq[$];
    int   jump_tbl[9] = '{15, 27, 34, 36, 36, 34, 27, 15, 0};

    task automatic model_reset();
        m_gs = ST_IDLE; m_score = 0; m_spd = INIT_SPEED;
        m_ol = SCREEN_W - 1; m_rex = 0;
        m_jq.delete();
    endtask

    // One frame of the game, applied in the order the rules state
    task automatic model_frame(input bit press, input int start_cyc);
        exp_t e;
        if (m_gs == ST_IDLE) begin
            if (press) begin
                m_gs = ST_RUN; m_score = 0; m_spd = INIT_SPEED;
                m_ol = SCREEN_W - 1; m_rex = 0; m_jq.delete();
            end
        end else if (m_gs == ST_OVER) begin
            if (press) begin
                m_gs = ST_IDLE; m_ol = SCREEN_W - 1; m_rex = 0; m_jq.delete();
            end
        end else begin
            if (press && m_jq.size() == 0)
                foreach (jump_tbl[i]) m_jq.push_back(jump_tbl[i]);
            if (m_jq.size() != 0) m_rex = m_jq.pop_front();
            if (m_ol < m_spd) begin
                m_ol = SCREEN_W - 1;
                if (m_score < 65535) begin
                    m_score++;
                    if (m_score % 8 == 0 && m_spd < MAX_SPEED) m_spd++;
                end
            end else begin
                m_ol = m_ol - m_spd;
            end
            if (m_ol + OBST_W > REX_X && m_ol < REX_X + REX_W && m_rex < OBST_H)
                m_gs = ST_OVER;
        end
        e.cyc = start_cyc; e.gs = m_gs; e.rex = m_rex; e.ol = m_ol; e.score = m_score;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: reset values while rstn low, scoreboard pop on each start_o
    always @(negedge clk) begin
        if (!ended) begin
            if (!rstn) begin
                chk("rst_start", int'(start_o), 0);
                chk("rst_rex", int'(rex_down), 0);
                chk("rst_obst", int'(obstacle_left), SCREEN_W - 1);
                chk("rst_state", int'(game_state), ST_IDLE);
                chk("rst_score", int'(score_o), 0);
            end else if (start_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_start: start_o high with no frame pending (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("start_cycle", cyc, e.cyc);
                    chk("game_state", int'(game_state), e.gs);
                    chk("rex_down", int'(rex_down), e.rex);
                    chk("obstacle_left", int'(obstacle_left), e.ol);
                    chk("score", int'(score_o), e.score);
                end
            end
            if (done || cyc > CYC_LIMIT) begin
                if (!done) begin
                    n_cmp++; n_bad++;
                    $display("FAIL timeout: stimulus still running at cycle %0d", cyc);
                end
                chk("pending_frames", exp_q.size(), 0);
                ended = 1;
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    task automatic run_frame(input bit press, input bit glitch);
        if (press) begin
            @(negedge clk) jmp_key = 1'b1;
            repeat (3) @(negedge clk);
            jmp_key = 1'b0;
        end
        repeat (2) @(negedge clk);
        @(negedge clk);
        model_frame(press, cyc + 5);
        frame_i = 1'b1;
        if (glitch) begin
            // Second edge lands in CHECK and must be ignored
            @(negedge clk) frame_i = 1'b0;
            @(negedge clk) frame_i = 1'b1;
            repeat (4) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
        frame_i = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic reset_mid_update();
        @(negedge clk) frame_i = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rstn = 1'b0;
        frame_i = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (4) @(negedge clk);
        #2 rstn = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        bit press, glitch, dumb;
        int nxt;
        rstn = 1'b1; frame_i = 1'b0; jmp_key = 1'b0;
        dumb = 0;
        model_reset();
        #3 rstn = 1'b0;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        repeat (3) @(negedge clk);

        for (int f = 0; f < N_FRAMES; f++) begin
            if (f == N_FRAMES / 2) reset_mid_update();
            glitch = ($urandom_range(0, 9) == 0);
            if (f < 5) begin
                press = 0;
            end else if (m_gs == ST_RUN) begin
                if (m_jq.size() == 0) begin
                    nxt = (m_ol >= m_spd) ? m_ol - m_spd : 1000;
                    press = dumb ? ($urandom_range(0, 19) == 0)
                                 : (nxt <= REX_X + REX_W + m_spd);
                end else begin
                    press = ($urandom_range(0, 4) == 0);
                end
                if (!dumb && $urandom_range(0, 399) == 0) dumb = 1;
            end else begin
                press = ($urandom_range(0, 2) == 0);
            end
            run_frame(press, glitch);
            if (m_gs == ST_OVER) dumb = 0;
        end
        repeat (10) @(negedge clk);
        done = 1;
    end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): SCREEN_W, 128, display width in pixels; REX_X, 8, rex left column; REX_W, 16, rex width; OBST_W, 8, obstacle width; OBST_H, 15, obstacle height; INIT_SPEED, 2, pixels per frame at game start; MAX_SPEED, 6, speed ceiling.
REQ-002 clk  input  1  120 kHz system clock; the block SHALL use one clock.
REQ-003 rstn  input  1  reset; SHALL be asynchronous, active-low.
REQ-004 frame_i  input  1  12 Hz square wave from the clock divider.
REQ-005 jmp_key  input  1  raw jump key, active-high, asynchronous to clk.
REQ-006 start_o  output  1  one-cycle refresh pulse to the LCD driver.
REQ-007 rex_down  output  16  rex vertical offset; values 0/15/27/34/36 only.
REQ-008 obstacle_left  output  16  obstacle x position, 0..SCREEN_W-1.
REQ-009 game_state  output  2  00 IDLE, 01 RUN, 10 OVER; 11 never driven.
REQ-010 score_o  output  16  obstacles cleared, binary.

Function
REQ-011 frame_i and jmp_key SHALL each pass a 2-flop synchronizer; rising edges SHALL be detected on synchronized values (frame_edge, jmp_edge), each one clk wide.
REQ-012 Phase FSM SHALL be WAIT -> UPDATE -> CHECK -> KICK -> WAIT; leaves WAIT on frame_edge; every other transition is unconditional, one clk each.
REQ-013 frame_edge during UPDATE/CHECK/KICK SHALL be dropped.
REQ-014 start_o SHALL be high exactly during KICK, i.e. 3 clk after the frame_edge cycle, in every game_state; all other outputs SHALL be stable from KICK until the next UPDATE.
REQ-015 jmp_edge in any phase SHALL set a jump-request flag; the flag SHALL be consumed (cleared) in UPDATE.
REQ-016 UPDATE in IDLE with request: game_state->RUN, score 0, speed INIT_SPEED, obstacle_left SCREEN_W-1, rex_down 0, jump index 0.
REQ-017 UPDATE in OVER with request: game_state->IDLE, obstacle_left SCREEN_W-1, rex_down 0; score held.
REQ-018 UPDATE in RUN: jump table 15,27,34,36,36,34,27,15,0, one entry per frame; a request while grounded SHALL start the table at entry 0 this UPDATE; a request while airborne SHALL be discarded.
REQ-019 UPDATE in RUN, obstacle: if obstacle_left < speed then obstacle_left = SCREEN_W-1 and score+1, else obstacle_left - speed; no underflow permitted.
REQ-020 score SHALL saturate at 65535; speed SHALL increment by 1 when the new score is a nonzero multiple of 8, saturating at MAX_SPEED.
REQ-021 CHECK in RUN: collision = (obstacle_left + OBST_W > REX_X) AND (obstacle_left < REX_X + REX_W) AND (rex_down < OBST_H), on post-UPDATE values, computed at 17 bits; collision SHALL set game_state OVER in CHECK.
REQ-022 In IDLE and OVER, positions SHALL be frozen except per REQ-016/017.
REQ-023 Jump and wrap in the same UPDATE SHALL both apply; collision uses both results.

Reset
REQ-024 While rstn low: start_o 0, rex_down 0, obstacle_left SCREEN_W-1, game_state 00, score_o 0, speed INIT_SPEED, phase WAIT, jump flag and index 0, synchronizers 0.
REQ-025 Reset asserted mid-phase SHALL abort immediately; no start_o pulse after rstn rises until a new frame_edge.

Verification
REQ-026 Reset, then frame_i edges, no key -> game_state 00, obstacle_left 127, one start_o per frame, 3 clk after synchronized edge.
REQ-027 IDLE, key press, next frame -> game_state 01, obstacle_left 127, score 0; following frame obstacle_left 125.
REQ-028 RUN grounded, key press -> rex_down 15,27,34,36,36,34,27,15,0 on nine consecutive frames; second press mid-jump ignored.
REQ-029 RUN, obstacle_left 1, speed 2 -> obstacle_left 127, score +1; at score 8 speed becomes 3.
REQ-030 RUN, rex_down 0, obstacle reaching 22 -> game_state 10 in CHECK of that frame, positions frozen next frames; key press -> IDLE.
REQ-031 Assert rstn during UPDATE -> all outputs at REQ-024 values immediately, no start_o pulse.
